// File: rtl/pmu_apb_master.sv
// pmu_apb_master
// APB initiator that programs PMU registers on behalf of an on-chip requester.
// Register commands are buffered in a small FIFO and issued in order as APB
// SETUP/ACCESS transfers. Each command gets exactly one response: OK, SLVERR
// or TIMEOUT.
//
// Ports:
//   pclk, preset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_err       response payload (err: 00 OK, 01 SLVERR, 10 TIMEOUT)
//   psel..pstrb             APB request outputs
//   prdata/pready/pslverr   APB completion inputs
//   busy                    FIFO non-empty or transfer in progress
//   err_count               saturating count of non-OK responses
module pmu_apb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          paddr,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  // Command FIFO
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  cmd_t          head;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = mem[rd_ptr];

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr,
                               wdata: cmd_wdata, strb: cmd_strb};
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM
  logic [WC_W-1:0] wait_cnt;
  logic            tmo_hit, done, abort;

  assign tmo_hit = (TIMEOUT != 0) && !pready && (wait_cnt == WC_LAST);

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // pready in the last allowed cycle takes priority over the abort
        if (pready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) | ~empty;

  // APB and response datapath; psel/penable are registered from the next state
  always_ff @(posedge pclk) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      err_count <= '0;
    end else begin
      psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable   <= (state_nxt == ACCESS);
      rsp_valid <= (state_nxt == RESP);

      if (pop) begin
        pwrite <= head.write;
        paddr  <= head.addr;
        pwdata <= head.write ? head.wdata : '0;
        pstrb  <= head.write ? head.strb  : '0;
      end

      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 1'b1;

      if (done) begin
        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
        rsp_err   <= pslverr ? 2'b01 : 2'b00;
      end else if (abort) begin
        rsp_rdata <= '0;
        rsp_err   <= 2'b10;
      end

      if (((done && pslverr) || abort) && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pmu_apb_master.sv
module tb_pmu_apb_master;
  localparam int FD  = 4;
  localparam int TMO = 8;
  localparam int ECW = 8;

  logic           pclk = 1'b0;
  logic           preset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_write = 1'b0;
  logic [31:0]    cmd_addr = '0;
  logic [31:0]    cmd_wdata = '0;
  logic [3:0]     cmd_strb = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [31:0]    rsp_rdata;
  logic [1:0]     rsp_err;
  logic           psel, penable, pwrite;
  logic [31:0]    paddr, pwdata;
  logic [3:0]     pstrb;
  logic [31:0]    prdata = '0;
  logic           pready = 1'b0;
  logic           pslverr = 1'b0;
  logic           busy;
  logic [ECW-1:0] err_count;

  pmu_apb_master #(.FIFO_DEPTH(FD), .TIMEOUT(TMO), .ERR_CNT_W(ECW)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .busy(busy), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_t;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_t;

  rsp_t exp_q[$];
  apb_t apb_q[$];
  int   rise_q[$];

  // Slave behaviour knobs
  int ws      = 0;
  bit stuck   = 1'b0;
  bit slv_err = 1'b0;
  int exp_err = 0;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a ^ 32'h0000_0078;
  endfunction

  // APB slave model
  int acc_n = 0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      acc_n++;
      pready  = !stuck && (acc_n > ws);
      pslverr = pready && slv_err;
      prdata  = pready ? rd_val(paddr) : 32'hDEAD_BEEF;
    end else begin
      acc_n   = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'hDEAD_BEEF;
    end
  end

  // Bus and response monitor
  apb_t cur;
  bit   sel_q = 1'b0, rv_q = 1'b0;
  int   sel_len = 0, acc_len = 0, last_sel_len = 0, last_acc = 0;
  int   acc_end_cyc = 0, n_rise = 0;

  always @(negedge pclk) begin
    if (!preset) begin
      if (penable && !psel) chk("pen_wo_sel", 32'(penable), 32'(psel));
      if (psel && !sel_q) begin
        n_rise++;
        rise_q.push_back(cyc);
        sel_len = 0;
        acc_len = 0;
        chk("setup_penable", 32'(penable), 0);
        if (apb_q.size() == 0) begin
          chk("apb_unexpected", 1, 0);
        end else begin
          cur = apb_q.pop_front();
          chk("setup_paddr", paddr, cur.addr);
          chk("setup_pwrite", 32'(pwrite), 32'(cur.w));
          chk("setup_pwdata", pwdata, cur.wdata);
          chk("setup_pstrb", 32'(pstrb), 32'(cur.strb));
        end
      end
      if (psel) begin
        sel_len++;
        if (penable) begin
          acc_len++;
          acc_end_cyc = cyc;
          chk("access_paddr", paddr, cur.addr);
          chk("access_pwdata", pwdata, cur.wdata);
        end
      end
      if (!psel && sel_q) begin
        last_sel_len = sel_len;
        last_acc     = acc_len;
      end
      if (rsp_valid && !rv_q) chk("rsp_latency", 32'(cyc - acc_end_cyc), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
      sel_q = psel;
      rv_q  = rsp_valid;
    end else begin
      sel_q = 1'b0;
      rv_q  = 1'b0;
    end
  end

  // Offer one command; expectations are queued when acceptance is certain
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    rsp_t r;
    apb_t p;
    int   n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    r.err   = stuck ? 2'b10 : (slv_err ? 2'b01 : 2'b00);
    r.rdata = (w || r.err != 2'b00) ? 32'h0 : rd_val(a);
    exp_q.push_back(r);
    p.w     = w;
    p.addr  = a;
    p.wdata = w ? d : 32'h0;
    p.strb  = w ? s : 4'h0;
    apb_q.push_back(p);
    if (r.err != 2'b00 && exp_err < 255) exp_err++;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb_pwrite", {27'h0, pwrite, pstrb}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, 29'h0} | rsp_rdata, 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_busy", 32'(busy), 0);
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // Single write, zero wait
    send(1'b1, 32'h0, 32'h1, 4'hF);
    drain("t1");
    chk("t1_sel_len", 32'(last_sel_len), 2);
    chk("t1_access_len", 32'(last_acc), 1);

    // Read with three wait cycles
    ws = 3;
    send(1'b0, 32'h48, 32'hFFFF_FFFF, 4'hA);
    drain("t2");
    chk("t2_access_len", 32'(last_acc), 4);
    ws = 0;

    // Timeout, then completion in the last allowed cycle
    stuck = 1'b1;
    send(1'b0, 32'h100, 32'h0, 4'h0);
    drain("t3a");
    chk("t3a_access_len", 32'(last_acc), TMO);
    chk("t3a_errcnt", 32'(err_count), 32'(exp_err));
    stuck = 1'b0;
    ws = TMO - 1;
    send(1'b0, 32'h104, 32'h0, 4'h0);
    drain("t3b");
    chk("t3b_access_len", 32'(last_acc), TMO);
    chk("t3b_errcnt", 32'(err_count), 32'(exp_err));
    ws = 0;

    // Back-pressure: one issued, four buffered, sixth refused
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(1'b1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 4'h3);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h2FF;
    chk("t5_full", 32'(cmd_ready), 0);
    n0 = n_rise;
    repeat (8) @(negedge pclk);
    chk("t5_no_issue", 32'(n_rise), 32'(n0));
    chk("t5_still_full", 32'(cmd_ready), 0);
    chk("t5_rsp_held", 32'(rsp_valid), 1);
    cmd_valid = 1'b0;
    rise_q.delete();
    rsp_ready = 1'b1;
    drain("t5");
    chk("t5_rises", 32'(rise_q.size()), 4);
    if (rise_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("t5_gap", 32'(rise_q[i] - rise_q[i-1]), 3);

    // Slave errors and counter saturation
    slv_err = 1'b1;
    send(1'b1, 32'h300, 32'h55, 4'h1);
    drain("t4a");
    chk("t4a_errcnt", 32'(err_count), 32'(exp_err));
    for (int i = 0; i < 300; i++)
      send(i[0], 32'h400 + 32'(4 * (i % 8)), 32'(i), 4'h5);
    drain("t4b");
    chk("t4b_saturate", 32'(err_count), 255);
    slv_err = 1'b0;

    // Reset during ACCESS with two commands queued
    ws = 5;
    send(1'b1, 32'h500, 32'h1, 4'hF);
    send(1'b1, 32'h504, 32'h2, 4'hF);
    send(1'b1, 32'h508, 32'h3, 4'hF);
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("t6_in_access", 32'(psel && penable), 1);
    preset = 1'b1;
    exp_q.delete();
    apb_q.delete();
    exp_err = 0;
    @(negedge pclk);
    preset = 1'b0;
    chk("t6_psel", 32'(psel), 0);
    chk("t6_penable", 32'(penable), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    chk("t6_errcnt", 32'(err_count), 0);
    n0 = n_rise;
    repeat (30) @(negedge pclk);
    chk("t6_no_apb", 32'(n_rise), 32'(n0));
    chk("t6_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
